// File: rtl/sq_age_issue_sched.sv
// Oldest-first store-queue issue scheduler: circular head/tail tracking,
// per-entry valid/issued bits and a single registered grant to the D-cache store port.

`ifndef SQ_SIZE
`define SQ_SIZE 8
`endif

module barrel_shift_dir0 #(
  parameter int W    = 8,
  parameter int SW   = $clog2(W),
  parameter bit CIRC = 1'b1
) (
  input  logic [W-1:0]  data,
  input  logic [SW-1:0] shamt,
  output logic [W-1:0]  result
);
  logic [2*W-1:0] ext;

  // Doubling the word turns a right shift into a rotate when CIRC is set
  assign ext    = CIRC ? {data, data} : {{W{1'b0}}, data};
  assign result = W'(ext >> shamt);
endmodule

// state | meaning
// IDLE  | no grant outstanding, issue_valid = 0
// HOLD  | grant for issue_idx presented, waiting for issue_ack
module sq_age_issue_sched #(
  parameter int N    = `SQ_SIZE,
  parameter int IDXW = $clog2(N)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            alloc_en,
  output logic            alloc_ok,
  output logic [IDXW-1:0] alloc_idx,
  input  logic [N-1:0]    entry_ready,
  output logic            issue_valid,
  output logic [IDXW-1:0] issue_idx,
  input  logic            issue_ack,
  input  logic            retire_en,
  input  logic            flush,
  output logic [IDXW-1:0] head_idx,
  output logic            full,
  output logic            empty,
  output logic [IDXW:0]   count
);
  typedef enum logic {IDLE, HOLD} state_t;

  state_t          state, state_nxt;
  logic [IDXW-1:0] tail;
  logic [IDXW-1:0] idx_nxt;
  logic [IDXW-1:0] off;
  logic [IDXW-1:0] sel;
  logic [N-1:0]    valid, issued, held, cand, rot;
  logic            retire_ok;
  logic            set_issued;

  assign full        = (count == (IDXW+1)'(N));
  assign empty       = (count == '0);
  assign alloc_ok    = alloc_en & ~full;
  assign alloc_idx   = tail;
  assign retire_ok   = retire_en & valid[head_idx] & issued[head_idx];
  assign issue_valid = (state == HOLD);

  // The entry sitting in the grant register is never a candidate again
  always_comb begin
    held = '0;
    if (state == HOLD) held[issue_idx] = 1'b1;
  end

  assign cand = valid & entry_ready & ~issued & ~held;

  barrel_shift_dir0 #(.W(N), .SW(IDXW), .CIRC(1'b1)) u_rot (
    .data   (cand),
    .shamt  (head_idx),
    .result (rot)
  );

  always_comb begin
    off = '0;
    for (int i = N-1; i >= 0; i--) begin
      if (rot[i]) off = IDXW'(i);
    end
  end

  assign sel = head_idx + off;

  always_comb begin
    state_nxt  = state;
    idx_nxt    = issue_idx;
    set_issued = 1'b0;
    case (state)
      IDLE: begin
        if (|cand) begin
          state_nxt = HOLD;
          idx_nxt   = sel;
        end
      end
      HOLD: begin
        if (issue_ack) begin
          set_issued = 1'b1;
          if (|cand) idx_nxt = sel;
          else state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      state     <= IDLE;
      issue_idx <= '0;
    end else begin
      state     <= state_nxt;
      issue_idx <= idx_nxt;
    end
  end

  // Alloc targets tail and retire targets head; these never collide because
  // alloc is blocked when full and retire needs a valid head.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head_idx <= '0;
      tail     <= '0;
      count    <= '0;
      valid    <= '0;
      issued   <= '0;
    end else begin
      if (alloc_ok) begin
        valid[tail]  <= 1'b1;
        issued[tail] <= 1'b0;
        tail         <= tail + IDXW'(1);
      end
      if (retire_ok) begin
        valid[head_idx] <= 1'b0;
        head_idx        <= head_idx + IDXW'(1);
      end
      if (set_issued) issued[issue_idx] <= 1'b1;
      count <= count + (IDXW+1)'(alloc_ok) - (IDXW+1)'(retire_ok);
    end
  end
endmodule
